// File: rtl/mem_bus_interface.sv
// mem_bus_interface: memory-access stage behind the MAR address mux.
// Captures address/store data on a control-unit request, runs an MFA/MOC
// handshake with memory, lane-aligns byte/half/word data and keeps load
// results in an internal MDR (rdata).
//
// Handshake: the control unit raises req for one cycle while busy is low.
// The request is accepted on that clock edge. busy is then high until done
// has pulsed. done and err are registered one-cycle pulses. A req seen while
// busy is dropped. On the memory side, mem_mfa stays high with stable
// mem_addr/mem_be/mem_wdata/mem_rw until mem_moc is sampled high, or until
// TIMEOUT cycles have passed without mem_moc.
//
// Optional build macro MEM_BUS_SIGN_EXT_EN adds the signed_ld input. When
// signed_ld is set, byte and half loads are sign-extended. When the macro is
// undefined, all sub-word loads are zero-extended.
module mem_bus_interface #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef MEM_BUS_SIGN_EXT_EN
  input  logic        signed_ld,
`endif
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_mfa,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_moc,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Last WAIT count value before the access is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mfa_q, mfa_d;
  logic        rw_q, rw_d;
  logic [31:0] maddr_q, maddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] mwdata_q, mwdata_d;
`ifdef MEM_BUS_SIGN_EXT_EN
  logic        sext_q, sext_d;
`endif

  // Request-side decode: alignment check, byte enables, lane replication.
  logic        req_bad;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  always_comb begin
    req_bad   = 1'b0;
    req_be    = 4'b0000;
    req_wdata = wdata;
    unique case (size)
      SZ_BYTE: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        req_bad   = addr[0];
        req_be    = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        req_bad   = (addr[1:0] != 2'b00);
        req_be    = 4'b1111;
        req_wdata = wdata;
      end
      default: begin
        req_bad   = 1'b1;
        req_be    = 4'b0000;
        req_wdata = wdata;
      end
    endcase
  end

  // Load lane extraction from the memory word, using the latched access.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;
  logic [31:0] ld_value;

  always_comb begin
    ld_byte = mem_rdata[7:0];
    unique case (lane_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
`ifdef MEM_BUS_SIGN_EXT_EN
    ld_signed = sext_q;
`else
    ld_signed = 1'b0;
`endif
    unique case (size_q)
      SZ_BYTE: ld_value = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_value = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_value = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic for the access FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    lane_d   = lane_q;
    rdata_d  = rdata_q;
    maddr_d  = maddr_q;
    be_d     = be_q;
    mwdata_d = mwdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mfa_d    = 1'b0;
    rw_d     = 1'b0;
`ifdef MEM_BUS_SIGN_EXT_EN
    sext_d   = sext_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d   = we;
          size_d = size;
          lane_d = addr[1:0];
`ifdef MEM_BUS_SIGN_EXT_EN
          sext_d = signed_ld;
`endif
          if (req_bad) begin
            // Rejected before any bus cycle is started.
            state_d = ST_COMPLETE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = ST_WAIT;
            cnt_d    = 8'd0;
            mfa_d    = 1'b1;
            rw_d     = we;
            maddr_d  = {addr[31:2], 2'b00};
            be_d     = req_be;
            mwdata_d = req_wdata;
          end
        end
      end
      ST_WAIT: begin
        if (mem_moc) begin
          // A completion in the same cycle as the timeout still wins.
          state_d = ST_COMPLETE;
          done_d  = 1'b1;
          if (!we_q) begin
            rdata_d = ld_value;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_COMPLETE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          mfa_d = 1'b1;
          rw_d  = we_q;
        end
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      lane_q   <= 2'b00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      mfa_q    <= 1'b0;
      rw_q     <= 1'b0;
      maddr_q  <= 32'd0;
      be_q     <= 4'b0000;
      mwdata_q <= 32'd0;
`ifdef MEM_BUS_SIGN_EXT_EN
      sext_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      lane_q   <= lane_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      mfa_q    <= mfa_d;
      rw_q     <= rw_d;
      maddr_q  <= maddr_d;
      be_q     <= be_d;
      mwdata_q <= mwdata_d;
`ifdef MEM_BUS_SIGN_EXT_EN
      sext_q   <= sext_d;
`endif
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_mfa   = mfa_q;
  assign mem_rw    = rw_q;
  assign mem_addr  = maddr_q;
  assign mem_be    = be_q;
  assign mem_wdata = mwdata_q;
  assign dbg_state = state_q;

endmodule
